fifo_burst_reader: RTL and testbench

- Read-side controller for `sync_fifo`. It drives the FIFO read port (`ren`/`read_data`/`fifo_empty`/`data_avail`) and re-presents the words as a valid/ready stream, grouped into framed bursts.
- A burst starts when `data_avail` reaches `BURST_LEN`, or when `flush` is high with the FIFO non-empty.
- Absorbs the FIFO's 1-cycle read latency with a 2-entry output buffer, so downstream backpressure never loses data.

---
 rtl/fifo_burst_reader_pkg.sv | 12 +
 rtl/fifo_out_buf.sv | 51 +++++
 rtl/fifo_burst_reader.sv | 97 +++++++++
 tb/tb_fifo_burst_reader.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_burst_reader_pkg.sv
// Shared definitions for the sync_fifo read-side burst controller.
// Default widths match sync_fifo; state encodings are shared by name.
package fifo_burst_reader_pkg;
    localparam int FIFO_PTR_DEF  = 4;
    localparam int FIFO_DATA_DEF = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BURST = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;
endpackage

// File: rtl/fifo_out_buf.sv
// 2-entry first-word-fall-through skid buffer.
// The head register drives the output directly, so data and valid are registered.
module fifo_out_buf
    import fifo_burst_reader_pkg::*;
#(
    parameter int W = FIFO_DATA_DEF
)(
    input  logic         clk,
    input  logic         rstb,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] data_in,
    output logic [W-1:0] data,
    output logic         valid,
    output logic [1:0]   occ
);
    logic [W-1:0] head, tail;

    // The parent never pops an empty buffer or pushes a full one without a pop.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            head <= '0;
            tail <= '0;
            occ  <= 2'd0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (occ == 2'd0) head <= data_in;
                    else             tail <= data_in;
                    occ <= occ + 2'd1;
                end
                2'b01: begin
                    head <= tail;
                    occ  <= occ - 2'd1;
                end
                2'b11: begin
                    if (occ == 2'd1) begin
                        head <= data_in;
                    end else begin
                        head <= tail;
                        tail <= data_in;
                    end
                end
                default: ;
            endcase
        end
    end

    assign data  = head;
    assign valid = (occ != 2'd0);
endmodule

// File: rtl/fifo_burst_reader.sv
// Read-side controller for sync_fifo: pulls framed bursts out of the FIFO and
// re-presents them as a valid/ready stream with out_last on the final beat.
module fifo_burst_reader
    import fifo_burst_reader_pkg::*;
#(
    parameter int FIFO_PTR  = FIFO_PTR_DEF,
    parameter int FIFO_DATA = FIFO_DATA_DEF,
    parameter int BURST_LEN = 4
)(
    input  logic                 clk,
    input  logic                 rstb,
    output logic                 fifo_ren,
    input  logic [FIFO_DATA-1:0] fifo_rdata,
    input  logic                 fifo_empty,
    input  logic [FIFO_PTR:0]    fifo_data_avail,
    input  logic                 flush,
    output logic                 out_valid,
    output logic [FIFO_DATA-1:0] out_data,
    output logic                 out_last,
    input  logic                 out_ready,
    output logic                 busy
);
    localparam int            CW   = FIFO_PTR + 1;
    localparam logic [CW-1:0] BLEN = CW'(BURST_LEN);

    state_t        state, state_nxt;
    logic [CW-1:0] beats, issued, delivered;
    logic [CW-1:0] issued_nxt, load_beats;
    logic          load;
    logic          inflight, pop, room_ok;
    logic [1:0]    occ;
    logic [2:0]    pending;

    assign pop      = out_valid && out_ready;
    assign pending  = {1'b0, occ} + {2'b00, inflight};
    // A full buffer blocks issue outright, even when this cycle pops.
    assign room_ok  = (occ != 2'd2) && (pending < (3'd2 + {2'b00, pop}));
    assign fifo_ren = (state == ST_BURST) && (issued < beats) && !fifo_empty && room_ok;

    assign issued_nxt = issued + {{(CW-1){1'b0}}, fifo_ren};
    assign busy       = (state != ST_IDLE);
    assign out_last   = out_valid && (delivered == (beats - {{(CW-1){1'b0}}, 1'b1}));

    always_comb begin
        state_nxt  = state;
        load       = 1'b0;
        load_beats = BLEN;
        case (state)
            ST_IDLE: begin
                if (fifo_data_avail >= BLEN) begin
                    state_nxt = ST_BURST;
                    load      = 1'b1;
                end else if (flush && !fifo_empty) begin
                    state_nxt  = ST_BURST;
                    load       = 1'b1;
                    load_beats = fifo_data_avail;
                end
            end
            ST_BURST: if (issued_nxt == beats) state_nxt = ST_DRAIN;
            ST_DRAIN: if (delivered == beats)  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state     <= ST_IDLE;
            beats     <= '0;
            issued    <= '0;
            delivered <= '0;
            inflight  <= 1'b0;
        end else begin
            state    <= state_nxt;
            inflight <= fifo_ren;
            if (load) begin
                beats     <= load_beats;
                issued    <= '0;
                delivered <= '0;
            end else begin
                issued    <= issued_nxt;
                delivered <= delivered + {{(CW-1){1'b0}}, pop};
            end
        end
    end

    // Read data lands one cycle after the strobe; capture it unconditionally.
    fifo_out_buf #(.W(FIFO_DATA)) u_buf (
        .clk     (clk),
        .rstb    (rstb),
        .push    (inflight),
        .pop     (pop),
        .data_in (fifo_rdata),
        .data    (out_data),
        .valid   (out_valid),
        .occ     (occ)
    );
endmodule

// File: tb/tb_fifo_burst_reader.sv
// Directed bench for fifo_burst_reader with a behavioural sync_fifo model.
module tb_fifo_burst_reader;
    logic        clk = 1'b0;
    logic        rstb, fifo_rstn;
    logic        fifo_ren, fifo_empty, flush, out_valid, out_last, out_ready, busy;
    logic [31:0] fifo_rdata, out_data;
    logic [4:0]  fifo_data_avail;
    logic        wr_en;
    logic [31:0] wr_data;
    logic        tog_en, tog_q;

    always #5 clk = ~clk;

    fifo_burst_reader #(.FIFO_PTR(4), .FIFO_DATA(32), .BURST_LEN(4)) dut (
        .clk(clk), .rstb(rstb), .fifo_ren(fifo_ren), .fifo_rdata(fifo_rdata),
        .fifo_empty(fifo_empty), .fifo_data_avail(fifo_data_avail), .flush(flush),
        .out_valid(out_valid), .out_data(out_data), .out_last(out_last),
        .out_ready(out_ready), .busy(busy)
    );

    // sync_fifo model: 16 deep, registered read data one cycle after ren
    logic [31:0] mem [16];
    logic [3:0]  wp, rp;
    logic [4:0]  cnt;
    always @(posedge clk or negedge fifo_rstn) begin
        if (!fifo_rstn) begin
            wp <= '0; rp <= '0; cnt <= '0; fifo_rdata <= '0;
        end else begin
            if (wr_en && cnt != 5'd16) begin
                mem[wp] <= wr_data;
                wp <= wp + 4'd1;
            end
            if (fifo_ren && cnt != 5'd0) begin
                fifo_rdata <= mem[rp];
                rp <= rp + 4'd1;
            end
            cnt <= cnt + {4'd0, wr_en && cnt != 5'd16} - {4'd0, fifo_ren && cnt != 5'd0};
        end
    end
    assign fifo_empty      = (cnt == 5'd0);
    assign fifo_data_avail = cnt;

    always @(posedge clk) tog_q <= ~tog_q;
    assign out_ready = tog_en ? tog_q : 1'b1;

    // Monitor: transfer log, idle gaps, and a reference model of buffer occupancy
    int          cyc = 0;
    logic [31:0] q_data[$];
    bit          q_last[$];
    int          q_cyc[$], ren_cyc[$], gaps[$];
    int          viol_empty = 0, viol_full = 0, viol_occ = 0, viol_stab = 0, viol_last = 0;
    int          tb_occ = 0, idle_run = 0;
    bit          seen_busy = 0, prev_ren = 0, prev_stall = 0;
    logic [31:0] prev_data = '0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!rstb) begin
            seen_busy = 0; idle_run = 0; tb_occ = 0; prev_ren = 0; prev_stall = 0;
        end else begin
            if (fifo_ren && fifo_empty) viol_empty++;
            if (fifo_ren && tb_occ == 2) viol_full++;
            if (out_valid != (tb_occ != 0)) viol_occ++;
            if (prev_stall && (!out_valid || out_data !== prev_data)) viol_stab++;
            if (out_last && !out_valid) viol_last++;
            if (out_valid && out_ready) begin
                q_data.push_back(out_data); q_last.push_back(out_last); q_cyc.push_back(cyc);
            end
            if (fifo_ren) ren_cyc.push_back(cyc);
            if (busy) begin
                if (seen_busy && idle_run > 0) gaps.push_back(idle_run);
                idle_run = 0; seen_busy = 1;
            end else if (seen_busy) idle_run++;
            tb_occ = tb_occ + int'(prev_ren) - int'(out_valid && out_ready);
            prev_ren = fifo_ren; prev_stall = out_valid && !out_ready; prev_data = out_data;
        end
    end

    int n_chk = 0, n_fail = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic put(input logic [31:0] d);
        wr_en = 1'b1; wr_data = d;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int stable = 0;
        for (int t = 0; t < 3000 && stable < 2; t++) begin
            tick();
            if (!busy && fifo_empty && !out_valid) stable++;
            else stable = 0;
        end
        n_chk++;
        if (stable < 2) begin
            n_fail++;
            $display("FAIL %s idle wait: busy=%0b empty=%0b valid=%0b, expected idle and empty",
                     name, busy, fifo_empty, out_valid);
        end
    endtask

    typedef struct {
        int          nwords;
        logic [31:0] base;
        bit          use_flush;
        bit          tog;
        bit          prefill;
        logic [15:0] last_mask;
        bit          consec;
    } vec_t;

    vec_t vecs[5];

    task automatic run_vec(input int v, input vec_t t);
        int qi = q_data.size();
        int ri = ren_cyc.size();
        int gi = gaps.size();
        logic [15:0] m = t.last_mask;
        logic [4:0]  room;
        tog_en = t.tog;
        if (t.prefill) rstb = 1'b0;
        for (int i = 0; i < t.nwords; i++) put(t.base + 32'(i));
        if (t.prefill) begin tick(); rstb = 1'b1; end
        if (t.use_flush) flush = 1'b1;
        wait_idle($sformatf("v%0d", v));
        flush = 1'b0; tog_en = 1'b0;
        check($sformatf("v%0d beat count", v), 32'(q_data.size() - qi), 32'(t.nwords));
        check($sformatf("v%0d ren count", v), 32'(ren_cyc.size() - ri), 32'(t.nwords));
        for (int i = 0; i < t.nwords && qi + i < q_data.size(); i++) begin
            check($sformatf("v%0d data[%0d]", v, i), q_data[qi+i], t.base + 32'(i));
            check($sformatf("v%0d last[%0d]", v, i), 32'(q_last[qi+i]), 32'(m[i]));
        end
        if (t.consec && q_data.size() - qi == t.nwords && ren_cyc.size() - ri == t.nwords)
            for (int i = 1; i < t.nwords; i++) begin
                check($sformatf("v%0d ren cycle[%0d]", v, i), 32'(ren_cyc[ri+i]), 32'(ren_cyc[ri] + i));
                check($sformatf("v%0d out cycle[%0d]", v, i), 32'(q_cyc[qi+i]), 32'(q_cyc[qi] + i));
            end
        if (t.prefill) begin
            check($sformatf("v%0d gap count", v), 32'(gaps.size() - gi), 32'd3);
            for (int i = gi; i < gaps.size(); i++)
                check($sformatf("v%0d gap[%0d]", v, i - gi), 32'(gaps[i]), 32'd1);
            room = 5'd16 - cnt;
            check($sformatf("v%0d room_avail", v), 32'(room), 32'd16);
        end
        check($sformatf("v%0d busy after", v), 32'(busy), 32'd0);
    endtask

    initial begin
        int qi, ri;
        vecs[0] = '{4,  32'hA34D, 1'b0, 1'b0, 1'b0, 16'h0008, 1'b1};
        vecs[1] = '{8,  32'h9C7B, 1'b0, 1'b1, 1'b0, 16'h0088, 1'b0};
        vecs[2] = '{16, 32'h1000, 1'b0, 1'b0, 1'b1, 16'h8888, 1'b0};
        vecs[3] = '{2,  32'h2000, 1'b1, 1'b0, 1'b0, 16'h0002, 1'b0};
        vecs[4] = '{5,  32'h5000, 1'b1, 1'b0, 1'b0, 16'h0018, 1'b0};

        rstb = 1'b0; fifo_rstn = 1'b0; flush = 1'b0; wr_en = 1'b0; wr_data = '0;
        tog_en = 1'b0; tog_q = 1'b0;
        tick(); tick();
        check("reset out_valid", 32'(out_valid), 32'd0);
        check("reset fifo_ren",  32'(fifo_ren),  32'd0);
        check("reset busy",      32'(busy),      32'd0);
        check("reset out_last",  32'(out_last),  32'd0);
        check("reset out_data",  out_data,       32'd0);
        rstb = 1'b1; fifo_rstn = 1'b1;
        tick();

        // Below threshold: nothing moves until flush
        qi = q_data.size(); ri = ren_cyc.size();
        for (int i = 0; i < 3; i++) put(32'h3000 + 32'(i));
        repeat (50) tick();
        check("below ren count", 32'(ren_cyc.size() - ri), 32'd0);
        check("below busy", 32'(busy), 32'd0);
        flush = 1'b1; tick(); flush = 1'b0;
        wait_idle("below");
        check("below beats", 32'(q_data.size() - qi), 32'd3);
        for (int i = 0; i < 3 && qi + i < q_data.size(); i++) begin
            check($sformatf("below data[%0d]", i), q_data[qi+i], 32'h3000 + 32'(i));
            check($sformatf("below last[%0d]", i), 32'(q_last[qi+i]), (i == 2) ? 32'd1 : 32'd0);
        end
        check("below empty", 32'(fifo_empty), 32'd1);

        // Empty stall: a 1-word flush burst, then a 2-word one
        qi = q_data.size();
        put(32'h4000);
        flush = 1'b1;
        wait_idle("stall1");
        flush = 1'b0;
        repeat (10) tick();
        put(32'h4001); put(32'h4002);
        flush = 1'b1;
        wait_idle("stall2");
        flush = 1'b0;
        check("stall beats", 32'(q_data.size() - qi), 32'd3);
        for (int i = 0; i < 3 && qi + i < q_data.size(); i++) begin
            check($sformatf("stall data[%0d]", i), q_data[qi+i], 32'h4000 + 32'(i));
            check($sformatf("stall last[%0d]", i), 32'(q_last[qi+i]), (i != 1) ? 32'd1 : 32'd0);
        end

        // Reset mid-burst after the 2nd beat
        qi = q_data.size();
        for (int i = 0; i < 4; i++) put(32'h6000 + 32'(i));
        for (int t = 0; t < 100 && q_data.size() - qi < 2; t++) tick();
        check("midrst beats before reset", 32'(q_data.size() - qi), 32'd2);
        rstb = 1'b0;
        #1;
        check("midrst out_valid", 32'(out_valid), 32'd0);
        check("midrst fifo_ren",  32'(fifo_ren),  32'd0);
        check("midrst busy",      32'(busy),      32'd0);
        fifo_rstn = 1'b0;
        tick();
        rstb = 1'b1; fifo_rstn = 1'b1;
        tick();
        check("midrst busy after release", 32'(busy), 32'd0);

        for (int v = 0; v < 5; v++) run_vec(v, vecs[v]);

        check("ren while empty",      32'(viol_empty), 32'd0);
        check("ren while buf full",   32'(viol_full),  32'd0);
        check("valid vs occupancy",   32'(viol_occ),   32'd0);
        check("stall stability",      32'(viol_stab),  32'd0);
        check("last without valid",   32'(viol_last),  32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
